// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared encodings, widths and score helper for the game session.
// Revision : 1.0
// ============================================================================
package game_pkg;

   localparam int COORD_W    = 5;
   localparam int SCORE_W    = 8;
   localparam int BONUS_STEP = 5;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_PLAY = 3'd2;
   localparam logic [2:0] ST_WIN  = 3'd3;
   localparam logic [2:0] ST_LOSE = 3'd4;

   localparam logic [1:0] LV_NONE = 2'd0;
   localparam logic [1:0] LV_EASY = 2'd1;
   localparam logic [1:0] LV_MED  = 2'd2;
   localparam logic [1:0] LV_HARD = 2'd3;

   // Add is clamped before subtract so a shared tile nets -5 from a saturated score.
   function automatic logic [SCORE_W-1:0] apply_bonus(input logic [SCORE_W-1:0] s,
                                                      input logic add,
                                                      input logic sub);
      logic [SCORE_W:0] t;
      t = {1'b0, s};
      if (add) begin
         t = t + (SCORE_W+1)'(BONUS_STEP);
         if (t[SCORE_W]) t = {1'b0, {SCORE_W{1'b1}}};
      end
      if (sub) begin
         if (t < (SCORE_W+1)'(BONUS_STEP)) t = '0;
         else t = t - (SCORE_W+1)'(BONUS_STEP);
      end
      return t[SCORE_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/game_tick_timer.sv
`default_nettype none
// ============================================================================
// Module   : game_tick_timer
// Brief    : One-second prescaler and saturating seconds-remaining counter.
// Revision : 1.0
// ============================================================================
module game_tick_timer #(
   parameter int TICK_DIV   = 50000000,
   parameter int TIME_LIMIT = 99
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       load,
   output logic       tick,
   output logic [7:0] time_left,
   output logic       expired
);

   localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [7:0]    r_time;

   assign tick      = enable && (r_cnt == c_last);
   assign time_left = r_time;
   assign expired   = (r_time == 8'd0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt  <= '0;
         r_time <= 8'(TIME_LIMIT);
      end else if (load) begin
         r_cnt  <= '0;
         r_time <= 8'(TIME_LIMIT);
      end else if (enable) begin
         if (tick) begin
            r_cnt <= '0;
            if (r_time != 8'd0) r_time <= r_time - 8'd1;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/game_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_session_ctrl
// Brief    : Maze game session sequencer: arm, load, timed play, bonus tiles.
// Revision : 1.0
// ============================================================================
module game_session_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV   = 50000000,
   parameter int TIME_LIMIT = 99,
   parameter int SCORE_INIT = 50
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               play_hard,
   input  logic               play_medium,
   input  logic               play_easy,
   input  logic               ext_reset,
   input  logic [COORD_W-1:0] plus_x,
   input  logic [COORD_W-1:0] plus_y,
   input  logic [COORD_W-1:0] minus_x,
   input  logic [COORD_W-1:0] minus_y,
   input  logic               start,
   input  logic               load_ack,
   input  logic               move_valid,
   input  logic [COORD_W-1:0] player_x,
   input  logic [COORD_W-1:0] player_y,
   input  logic               at_exit,
   output logic               load_req,
   output logic [1:0]         level,
   output logic [2:0]         state,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         time_left,
   output logic               plus_used,
   output logic               minus_used,
   output logic               game_won,
   output logic               game_lost
);

   logic [2:0]         r_state;
   logic [1:0]         r_level;
   logic [COORD_W-1:0] r_plus_x, r_plus_y, r_minus_x, r_minus_y;
   logic [SCORE_W-1:0] r_score;
   logic               r_plus_used, r_minus_used;

   logic [1:0] w_sel_level;
   logic       w_arm, w_abort, w_in_play, w_hit_plus, w_hit_minus;
   logic       w_expired, w_unused_tick;

   always_comb begin
      w_sel_level = LV_NONE;
      if (play_hard)        w_sel_level = LV_HARD;
      else if (play_medium) w_sel_level = LV_MED;
      else if (play_easy)   w_sel_level = LV_EASY;
   end

   assign w_arm       = (r_state == ST_IDLE) && start && $onehot({play_hard, play_medium, play_easy});
   assign w_abort     = (r_state != ST_IDLE) && ext_reset;
   assign w_in_play   = (r_state == ST_PLAY);
   assign w_hit_plus  = w_in_play && move_valid && !r_plus_used &&
                        (player_x == r_plus_x) && (player_y == r_plus_y);
   assign w_hit_minus = w_in_play && move_valid && !r_minus_used &&
                        (player_x == r_minus_x) && (player_y == r_minus_y);

   // An abort freezes the clock so the timer never runs on the way out of PLAY.
   game_tick_timer #(
      .TICK_DIV   (TICK_DIV),
      .TIME_LIMIT (TIME_LIMIT)
   ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .enable    (w_in_play && !ext_reset),
      .load      (w_arm),
      .tick      (w_unused_tick),
      .time_left (time_left),
      .expired   (w_expired)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_level      <= LV_NONE;
         r_plus_x     <= '0;
         r_plus_y     <= '0;
         r_minus_x    <= '0;
         r_minus_y    <= '0;
         r_score      <= SCORE_W'(SCORE_INIT);
         r_plus_used  <= 1'b0;
         r_minus_used <= 1'b0;
      end else if (w_abort) begin
         r_state      <= ST_IDLE;
         r_level      <= LV_NONE;
         r_plus_used  <= 1'b0;
         r_minus_used <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_arm) begin
                  r_state      <= ST_LOAD;
                  r_level      <= w_sel_level;
                  r_plus_x     <= plus_x;
                  r_plus_y     <= plus_y;
                  r_minus_x    <= minus_x;
                  r_minus_y    <= minus_y;
                  r_score      <= SCORE_W'(SCORE_INIT);
                  r_plus_used  <= 1'b0;
                  r_minus_used <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (load_ack) r_state <= ST_PLAY;
            end
            ST_PLAY: begin
               r_score <= apply_bonus(r_score, w_hit_plus, w_hit_minus);
               if (w_hit_plus)  r_plus_used  <= 1'b1;
               if (w_hit_minus) r_minus_used <= 1'b1;
               // Reaching the exit outranks running out of time on the same cycle.
               if (move_valid && at_exit) r_state <= ST_WIN;
               else if (w_expired)        r_state <= ST_LOSE;
            end
            ST_WIN, ST_LOSE: begin
               if (start) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign state      = r_state;
   assign level      = r_level;
   assign score      = r_score;
   assign load_req   = (r_state == ST_LOAD);
   assign plus_used  = r_plus_used;
   assign minus_used = r_minus_used;
   assign game_won   = (r_state == ST_WIN);
   assign game_lost  = (r_state == ST_LOSE);

endmodule
`default_nettype wire

// File: tb/tb_game_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_session_ctrl
// Brief    : Scoreboard bench for game_session_ctrl against a rule-level model.
// Revision : 1.0
// ============================================================================
module tb_game_session_ctrl;

   localparam int TICK_DIV   = 4;
   localparam int TIME_LIMIT = 5;
   localparam int SCORE_INIT = 252;
   localparam int IDLE = 0, LOAD = 1, PLAY = 2, WIN = 3, LOSE = 4;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       play_hard = 0, play_medium = 0, play_easy = 0, ext_reset = 0;
   logic [4:0] plus_x = 0, plus_y = 0, minus_x = 0, minus_y = 0;
   logic       start = 0, load_ack = 0, move_valid = 0, at_exit = 0;
   logic [4:0] player_x = 0, player_y = 0;
   logic       load_req, plus_used, minus_used, game_won, game_lost;
   logic [1:0] level;
   logic [2:0] state;
   logic [7:0] score, time_left;

   game_session_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .TIME_LIMIT (TIME_LIMIT),
      .SCORE_INIT (SCORE_INIT)
   ) dut (
      .clock (clock), .resetn (resetn),
      .play_hard (play_hard), .play_medium (play_medium), .play_easy (play_easy),
      .ext_reset (ext_reset),
      .plus_x (plus_x), .plus_y (plus_y), .minus_x (minus_x), .minus_y (minus_y),
      .start (start), .load_ack (load_ack), .move_valid (move_valid),
      .player_x (player_x), .player_y (player_y), .at_exit (at_exit),
      .load_req (load_req), .level (level), .state (state), .score (score),
      .time_left (time_left), .plus_used (plus_used), .minus_used (minus_used),
      .game_won (game_won), .game_lost (game_lost)
   );

   always #5 clock = ~clock;

   typedef struct {
      int st; int lv; int lr; int sc; int tl; int pu; int mu; int gw; int gl;
   } snap_t;

   snap_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: session facts, with time derived from elapsed play cycles.
   int m_st, m_lv, m_sc, m_elapsed, m_pu, m_mu;
   int m_px, m_py, m_mx, m_my;

   function automatic int time_now();
      int t;
      t = TIME_LIMIT - m_elapsed / TICK_DIV;
      return (t < 0) ? 0 : t;
   endfunction

   function automatic void model_reset();
      m_st = IDLE; m_lv = 0; m_sc = SCORE_INIT; m_elapsed = 0; m_pu = 0; m_mu = 0;
      m_px = 0; m_py = 0; m_mx = 0; m_my = 0;
   endfunction

   function automatic void model_step();
      int nsel, t_before;
      nsel     = int'(play_easy) + int'(play_medium) + int'(play_hard);
      t_before = time_now();
      if (m_st == IDLE) begin
         if (start && nsel == 1) begin
            m_lv = play_hard ? 3 : (play_medium ? 2 : 1);
            m_px = int'(plus_x);  m_py = int'(plus_y);
            m_mx = int'(minus_x); m_my = int'(minus_y);
            m_sc = SCORE_INIT; m_elapsed = 0; m_pu = 0; m_mu = 0;
            m_st = LOAD;
         end
      end else if (ext_reset) begin
         m_st = IDLE; m_lv = 0; m_pu = 0; m_mu = 0;
      end else if (m_st == LOAD) begin
         if (load_ack) m_st = PLAY;
      end else if (m_st == PLAY) begin
         m_elapsed++;
         if (move_valid) begin
            if (int'(player_x) == m_px && int'(player_y) == m_py && m_pu == 0) begin
               m_sc = (m_sc + 5 > 255) ? 255 : m_sc + 5;
               m_pu = 1;
            end
            if (int'(player_x) == m_mx && int'(player_y) == m_my && m_mu == 0) begin
               m_sc = (m_sc < 5) ? 0 : m_sc - 5;
               m_mu = 1;
            end
         end
         if (move_valid && at_exit) m_st = WIN;
         else if (t_before == 0)    m_st = LOSE;
      end else begin
         if (start) m_st = IDLE;
      end
   endfunction

   function automatic snap_t expect_now();
      snap_t s;
      s.st = m_st; s.lv = m_lv; s.lr = (m_st == LOAD) ? 1 : 0; s.sc = m_sc;
      s.tl = time_now(); s.pu = m_pu; s.mu = m_mu;
      s.gw = (m_st == WIN) ? 1 : 0; s.gl = (m_st == LOSE) ? 1 : 0;
      return s;
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s.st = int'(state); s.lv = int'(level); s.lr = int'(load_req); s.sc = int'(score);
      s.tl = int'(time_left); s.pu = int'(plus_used); s.mu = int'(minus_used);
      s.gw = int'(game_won); s.gl = int'(game_lost);
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_snap(input string tag, input snap_t a, input snap_t e);
      chk({tag, ".state"}, a.st, e.st);
      chk({tag, ".level"}, a.lv, e.lv);
      chk({tag, ".load_req"}, a.lr, e.lr);
      chk({tag, ".score"}, a.sc, e.sc);
      chk({tag, ".time_left"}, a.tl, e.tl);
      chk({tag, ".plus_used"}, a.pu, e.pu);
      chk({tag, ".minus_used"}, a.mu, e.mu);
      chk({tag, ".game_won"}, a.gw, e.gw);
      chk({tag, ".game_lost"}, a.gl, e.gl);
   endtask

   // Monitor: one expectation is queued per clock edge the model has advanced over.
   initial begin
      snap_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp_snap("cycle", observe(), e);
         end
      end
   end

   task automatic step();
      model_step();
      q.push_back(expect_now());
      @(negedge clock);
      start = 0; load_ack = 0; move_valid = 0; at_exit = 0; ext_reset = 0;
   endtask

   task automatic set_sel(input int lv);
      play_easy = (lv == 1); play_medium = (lv == 2); play_hard = (lv == 3);
   endtask

   task automatic arm(input int lv, input int px, input int py, input int mx, input int my);
      set_sel(lv);
      plus_x = 5'(px); plus_y = 5'(py); minus_x = 5'(mx); minus_y = 5'(my);
      start = 1;
      step();
   endtask

   task automatic move(input int x, input int y, input logic ex);
      move_valid = 1; player_x = 5'(x); player_y = 5'(y); at_exit = ex;
      step();
   endtask

   task automatic wait_model(input int target, input int limit);
      int n;
      n = 0;
      while (m_st != target && n < limit) begin
         step();
         n++;
      end
      chk("wait_state_reached", m_st, target);
   endtask

   task automatic async_reset();
      #2 resetn = 0;
      #1;
      model_reset();
      cmp_snap("async_reset", observe(), expect_now());
      @(negedge clock);
      resetn = 1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n, pick;
      model_reset();
      @(negedge clock);
      #1;
      cmp_snap("reset", observe(), expect_now());
      resetn = 1;
      @(negedge clock);

      // Invalid selection and IDLE abort are both no-ops.
      play_hard = 1; play_medium = 1; start = 1;
      step();
      ext_reset = 1;
      step();

      // Easy session: saturating plus, minus, revisits, move ignored in LOAD.
      arm(1, 17, 9, 10, 9);
      move(17, 9, 0);
      step(); step();
      load_ack = 1;
      step();
      move(17, 9, 0);
      move(17, 9, 0);
      move(10, 9, 0);
      move(10, 9, 0);
      move(3, 3, 1);
      step();
      start = 1;
      step();

      // Shared tile: add clamps first, then subtract.
      arm(2, 6, 6, 6, 6);
      load_ack = 1;
      step();
      move(6, 6, 0);
      ext_reset = 1;
      step();

      // Timeout to LOSE, then acknowledge back to IDLE.
      arm(3, 1, 21, 3, 5);
      load_ack = 1;
      step();
      wait_model(LOSE, 100);
      step();
      start = 1;
      step();

      // Exit on the very cycle time_left has reached zero.
      arm(1, 2, 2, 4, 4);
      load_ack = 1;
      step();
      n = 0;
      while (!(m_st == PLAY && time_now() == 0) && n < 100) begin
         step();
         n++;
      end
      chk("expiry_reached", time_now(), 0);
      move(9, 9, 1);
      step();

      // Abort with no selection, then switch changes during a new session.
      set_sel(0); ext_reset = 1;
      step();
      arm(2, 2, 2, 4, 4);
      load_ack = 1;
      step();
      set_sel(3); plus_x = 11; plus_y = 12; minus_x = 13; minus_y = 14;
      move(11, 12, 0);
      move(2, 2, 0);
      move(13, 14, 0);
      move(4, 4, 0);

      // Asynchronous reset during LOAD.
      ext_reset = 1;
      step();
      arm(1, 1, 1, 2, 2);
      async_reset();
      step();

      for (int i = 0; i < 3000; i++) begin
         {play_hard, play_medium, play_easy} = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) set_sel(int'($urandom_range(1, 3)));
         plus_x  = 5'($urandom_range(0, 3)); plus_y  = 5'($urandom_range(0, 3));
         minus_x = 5'($urandom_range(0, 3)); minus_y = 5'($urandom_range(0, 3));
         start      = ($urandom_range(0, 9) == 0);
         load_ack   = ($urandom_range(0, 3) == 0);
         ext_reset  = ($urandom_range(0, 99) == 0);
         move_valid = ($urandom_range(0, 1) == 1);
         at_exit    = ($urandom_range(0, 24) == 0);
         pick = int'($urandom_range(0, 2));
         if (pick == 0) begin
            player_x = 5'(m_px); player_y = 5'(m_py);
         end else if (pick == 1) begin
            player_x = 5'(m_mx); player_y = 5'(m_my);
         end else begin
            player_x = 5'($urandom_range(0, 31)); player_y = 5'($urandom_range(0, 31));
         end
         step();
      end

      @(negedge clock);
      @(negedge clock);
      chk("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
- Sequences one maze game session: arms on a valid difficulty selection plus start, requests the maze load, runs the play timer, applies one-shot ±5 bonus tiles, and declares win/lose.
- Sits between the combinational difficulty decoder (one-hot play level, bonus tile coordinates, external reset) and the maze/VGA datapath.
- Latches the decoder's selection at session start. Switch changes during play therefore cannot move tiles or change the level.

Parameters:
TICK_DIV, 50000000, clock cycles per one-second game tick
TIME_LIMIT, 99, session length in seconds (1..255)
SCORE_INIT, 50, score loaded at session start (0..255)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
play_hard  in  1  decoder one-hot level: hard
play_medium  in  1  decoder one-hot level: medium
play_easy  in  1  decoder one-hot level: easy
ext_reset  in  1  decoder: no difficulty selected (abort request)
plus_x, plus_y  in  5 each  decoder +5 tile coordinate
minus_x, minus_y  in  5 each  decoder -5 tile coordinate
start  in  1  single-cycle start/acknowledge pulse
load_ack  in  1  maze datapath finished loading
move_valid  in  1  player position updated this cycle
player_x, player_y  in  5 each  player tile coordinate (qualified by move_valid)
at_exit  in  1  player is on exit tile (qualified by move_valid)
load_req  out  1  maze load request
level  out  2  latched level: 0 none, 1 easy, 2 medium, 3 hard
state  out  3  current FSM state encoding
score  out  8  current score
time_left  out  8  seconds remaining
plus_used, minus_used  out  1 each  bonus tile consumed
game_won, game_lost  out  1 each  terminal flags

Behaviour:
- Reset (async, resetn=0): state=IDLE, level=0, load_req=0, score=SCORE_INIT, time_left=TIME_LIMIT, tick counter=0, all flags=0, latched tile coordinates=0.
- States: IDLE=0, LOAD=1, PLAY=2, WIN=3, LOSE=4. All transitions are registered and take effect 1 cycle after the cause.
- IDLE -> LOAD: start=1 and exactly one play_* is high.
  - Same edge: latch level, plus/minus coordinates; score=SCORE_INIT; time_left=TIME_LIMIT; clear flags and tick counter.
  - start with no valid selection is ignored.
- LOAD:
  - load_req=1 while in LOAD.
  - Leaves on load_ack=1 -> PLAY; load_req drops the same edge.
  - load_ack in any other state is ignored.
- PLAY tick counter:
  - Tick counter counts 0..TICK_DIV-1.
  - At wrap, time_left decrements, saturating at 0.
  - time_left reaching 0 -> LOSE on the following cycle.
- PLAY on move_valid:
  - (player_x,player_y)==plus tile and !plus_used: score=min(score+5,255); plus_used=1.
  - (player_x,player_y)==minus tile and !minus_used: score=max(score-5,0); minus_used=1.
  - If both tiles match the same position, both apply in the same cycle: clamp the add first, then the subtract, and set both flags.
  - A revisited tile has no effect.
  - at_exit=1 -> WIN. The bonus on the same move is still applied.
- Simultaneous exit and time expiry (time_left==0 on the exit cycle): WIN has priority.
- WIN: game_won=1. LOSE: game_lost=1. score and time_left freeze. start -> IDLE and clears terminal flags; level is retained until the next arm.
- Abort: ext_reset=1 in LOAD/PLAY/WIN/LOSE -> IDLE next cycle; load_req=0, level=0, flags cleared. This has priority over every other transition. ext_reset in IDLE has no effect.
- resetn asserted mid-session: immediate return to reset values. No load handshake is completed.
- move_valid outside PLAY is ignored.

Decomposition:
- Shared package game_pkg:
  - state encodings (IDLE..LOSE)
  - level codes (NONE/EASY/MED/HARD)
  - COORD_W=5, SCORE_W=8, BONUS_STEP=5
- One natural sub-module: game_tick_timer.
  - Holds the TICK_DIV prescaler and time_left down-counter.
  - Ports: enable, load, tick, time_left, expired.
  - Keeps the FSM free of divider logic.
- The bench uses TICK_DIV=4 for speed.

Test Plan:
- Easy: play_easy=1, tiles (17,9)/(10,9), start, load_ack after 3 cycles -> level=1, load_req high exactly in LOAD, state PLAY. Move to (17,9) -> score 55, plus_used=1; move to (17,9) again -> score stays 55.
- Hard, score saturation: SCORE_INIT=253, hard tiles (1,21)/(3,5). Move to (1,21) -> 255; move to (3,5) -> 250.
- Timeout: TIME_LIMIT=3, TICK_DIV=4, no moves -> time_left 3,2,1,0 at 4-cycle spacing, then state LOSE, game_lost=1. start -> IDLE with flags cleared.
- Exit and expiry: move_valid with at_exit=1 in the cycle time_left becomes 0 -> WIN, game_won=1, game_lost=0.
- Abort: during PLAY drive ext_reset=1 with all play_*=0 -> IDLE next cycle, level=0, score frozen value irrelevant. Then change switches during PLAY of a new session -> latched tiles unchanged.
- Reset and invalid start: assert resetn=0 in LOAD -> all outputs at reset values asynchronously. start with play_hard=play_med=1 -> remains IDLE.
